// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int   P_DATA_BITS   = 8;
   localparam logic P_PARITY_EVEN = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is selectable
// so an idle-high line does not look like an edge when reset releases.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Mid-bit sampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
// Good bytes appear on data_o with a one-cycle rx_done_o; faulty frames are flagged and dropped.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       rx_done_o,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       busy_o
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [2:0]    LAST_BIT  = 3'(P_DATA_BITS - 1);

   state_t                 state;
   state_t                 state_next;
   logic                   rx_s;
   logic [CW-1:0]          clk_cnt;
   logic [2:0]             bit_cnt;
   logic [P_DATA_BITS-1:0] shift_q;
   logic [7:0]             data_q;
   logic                   done_q;
   logic                   ferr_q;
   logic                   cnt_clr;
   logic                   shift_en;
   logic                   done_set;
   logic                   ferr_set;
`ifdef UART_RX_PARITY_EN
   logic                   perr;
   logic                   perr_q;
   logic                   perr_set;
   logic                   perr_load;
`endif

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_i),
      .q     (rx_s)
   );

   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      shift_en   = 1'b0;
      done_set   = 1'b0;
      ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set   = 1'b0;
      perr_load  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            cnt_clr = 1'b1;
            if (!rx_s) state_next = S_START;
         end
         S_START: begin
            if (clk_cnt == HALF_LAST) state_next = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            // Counter restarts at every sample, so non power-of-two bit periods work.
            if (clk_cnt == BIT_LAST) begin
               shift_en = 1'b1;
               cnt_clr  = 1'b1;
               if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (clk_cnt == BIT_LAST) begin
               perr_load  = 1'b1;
               state_next = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Framing error wins over a parity error; leaving at mid-stop catches a back-to-back start.
            if (clk_cnt == BIT_LAST) begin
               if (!rx_s) begin
                  ferr_set   = 1'b1;
                  state_next = S_BREAK;
               end
`ifdef UART_RX_PARITY_EN
               else if (perr) begin
                  perr_set   = 1'b1;
                  state_next = S_IDLE;
               end
`endif
               else begin
                  done_set   = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         S_BREAK: begin
            cnt_clr = 1'b1;
            if (rx_s) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (state_next != state) cnt_clr = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_next;
         clk_cnt <= cnt_clr ? '0 : clk_cnt + CNT_ONE;
         if (state == S_START)  bit_cnt <= '0;
         else if (shift_en)     bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) shift_q <= {rx_s, shift_q[P_DATA_BITS-1:1]};
         if (done_set) data_q  <= shift_q;
         done_q  <= done_set;
         ferr_q  <= ferr_set;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Even parity: data bits XOR parity bit must come out as P_PARITY_EVEN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr   <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         if (state == S_START) perr <= 1'b0;
         else if (perr_load)   perr <= ((^shift_q) ^ rx_s) != P_PARITY_EVEN;
         perr_q <= perr_set;
      end
   end

   assign parity_err_o = perr_q;
`else
   assign parity_err_o = 1'b0;
`endif

   assign data_o      = data_q;
   assign rx_done_o   = done_q;
   assign frame_err_o = ferr_q;
   assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames driven bit-aligned into uart_rx, checked against a frame-level model.
module tb_uart_rx;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] last_good = 8'h00;
   int exp_ferr = 0;
   int exp_perr = 0;

   int done_cycles = 0, done_pulses = 0;
   int ferr_cycles = 0, ferr_pulses = 0;
   int perr_cycles = 0, perr_pulses = 0;
   int busy_bad = 0;
   logic done_prev = 1'b0, ferr_prev = 1'b0, perr_prev = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_i         (rx),
      .data_o       (data),
      .rx_done_o    (rx_done),
      .frame_err_o  (frame_err),
      .parity_err_o (parity_err),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   // Monitor: collect strobed bytes and pulse statistics away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_done) begin
            got_q.push_back(data);
            done_cycles++;
            if (!done_prev) done_pulses++;
         end
         if (frame_err) begin
            ferr_cycles++;
            if (!ferr_prev) ferr_pulses++;
         end
         if (parity_err) begin
            perr_cycles++;
            if (!perr_prev) perr_pulses++;
         end
         if (done_prev && busy) busy_bad++;
      end
      done_prev = rx_done;
      ferr_prev = frame_err;
      perr_prev = parity_err;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      logic [10:0] bits;
      int n;
`ifdef UART_RX_PARITY_EN
      bits = {stop, par, b, 1'b0};
      n = 11;
`else
      bits = {par, stop, b, 1'b0};
      n = 10;
`endif
      for (int i = 0; i < n; i++) begin
         @(negedge clk) rx = bits[i];
         repeat (CPB - 1) @(negedge clk);
      end
   endtask

   // Frame-level model: which outcome a frame should produce.
   task automatic frame(input logic [7:0] b, input logic par, input logic stop);
      logic par_ok;
      par_ok = ((^b) ^ par) == 1'b0;
`ifndef UART_RX_PARITY_EN
      par_ok = 1'b1;
`endif
      if (!stop)        exp_ferr++;
      else if (!par_ok) exp_perr++;
      else begin
         exp_q.push_back(b);
         last_good = b;
      end
      send_frame(b, par, stop);
   endtask

   task automatic drain(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check(tag, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      logic       flip;

      // Reset state
      wait_cycles(3);
      check("rst_data", data, 8'h00);
      check("rst_done", rx_done, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      check("rst_perr", parity_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      wait_cycles(5);
      check("idle_busy", busy, 1'b0);

      // Single good byte
      frame(8'hA5, ^8'hA5, 1'b1);
      wait_cycles(4);
      drain("a5");
      check("a5_data", data, 8'hA5);
      check("a5_busy", busy, 1'b0);

      // Back-to-back command sequence with no idle gap
      frame(8'h01, ^8'h01, 1'b1);
      frame(8'h02, ^8'h02, 1'b1);
      frame(8'h7F, ^8'h7F, 1'b1);
      wait_cycles(4);
      drain("b2b");
      check("b2b_data", data, 8'h7F);

      // Short glitch: busy latency, then a silent false start
      @(negedge clk) rx = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("glitch_busy_early", busy, 1'b0);
      @(posedge clk); #1;
      check("glitch_busy_rise", busy, 1'b1);
      @(negedge clk) rx = 1'b1;
      wait_cycles(20);
      check("glitch_busy_end", busy, 1'b0);
      drain("glitch");
      check("glitch_ferr", ferr_pulses, exp_ferr);
      check("glitch_perr", perr_pulses, exp_perr);

      // Framing error with line then held low
      frame(8'h3C, ^8'h3C, 1'b0);
      wait_cycles(40);
      check("brk_busy", busy, 1'b1);
      check("brk_ferr", ferr_pulses, exp_ferr);
      check("brk_data", data, last_good);
      drain("brk");
      @(negedge clk) rx = 1'b1;
      wait_cycles(6);
      check("brk_release_busy", busy, 1'b0);
      check("brk_ferr_once", ferr_pulses, exp_ferr);
      frame(8'hC3, ^8'hC3, 1'b1);
      wait_cycles(4);
      drain("recover");
      check("recover_data", data, 8'hC3);

      // Reset during bit 4 of 8'hFF
      @(negedge clk) rx = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) rx = 1'b1;
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk) rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      last_good = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(20);
      check("abort_busy", busy, 1'b0);
      check("abort_data", data, last_good);
      drain("abort");
      frame(8'h55, ^8'h55, 1'b1);
      wait_cycles(4);
      drain("after_abort");
      check("after_abort_data", data, 8'h55);

`ifdef UART_RX_PARITY_EN
      // Parity: wrong bit then correct bit
      frame(8'h03, 1'b1, 1'b1);
      wait_cycles(4);
      check("par_bad_perr", perr_pulses, exp_perr);
      check("par_bad_data", data, 8'h55);
      drain("par_bad");
      frame(8'h03, 1'b0, 1'b1);
      wait_cycles(4);
      drain("par_good");
      check("par_good_data", data, 8'h03);
`endif

      // Randomized frames with random idle gaps and occasional bad parity
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom_range(0, 255));
         flip = ($urandom_range(0, 3) == 0);
         frame(b, (^b) ^ flip, 1'b1);
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      wait_cycles(6);
      drain("rand");
      check("rand_data", data, last_good);

      // Pulse totals and widths
      check("ferr_total", ferr_pulses, exp_ferr);
      check("perr_total", perr_pulses, exp_perr);
      check("done_width", done_cycles, done_pulses);
      check("ferr_width", ferr_cycles, ferr_pulses);
      check("perr_width", perr_cycles, perr_pulses);
      check("busy_after_done", busy_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns the host UART line into bytes for the register-command FSM directly downstream. Samples an asynchronous 8N1 line (8E1 when parity is compiled in) at mid-bit, and presents each good byte on `data_o` with a one-cycle `rx_done_o` strobe. That strobe feeds the command FSM's `rx_done_i`/`data_i` pair. Framing and parity faults are flagged and their bytes dropped.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per bit. Legal range ≥ 4.
- `clk  in  1`: system clock, rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `rx_i  in  1`: serial line, asynchronous to `clk`, idle high.
- `data_o  out  8`: last good byte, LSB received first. Holds between strobes.
- `rx_done_o  out  1`: one-cycle pulse when `data_o` updates.
- `frame_err_o  out  1`: one-cycle pulse when the stop bit samples low.
- `parity_err_o  out  1`: one-cycle pulse on parity mismatch. Constant 0 when parity is compiled out.
- `busy_o  out  1`: high in every state except `S_IDLE`.

## Operation
- `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- Bit counter `bit_cnt` is 3 bits. Baud counter `clk_cnt` is $clog2(CLKS_PER_BIT) bits, unsigned, and is cleared on every state entry.
- States: `S_IDLE`, `S_START`, `S_DATA`, `S_PARITY` (compiled in only with parity), `S_STOP`, `S_BREAK`.
- `S_IDLE`: when `rx_s` == 0, go to `S_START`.
- `S_START`: at `clk_cnt` == CLKS_PER_BIT/2 − 1 (integer division), sample `rx_s`.
  - Sample 0: go to `S_DATA` with `bit_cnt` = 0.
  - Sample 1: false start, return to `S_IDLE`. No flag is raised.
- `S_DATA`: at `clk_cnt` == CLKS_PER_BIT − 1, shift `rx_s` into the MSB of the shift register (right shift) and increment `bit_cnt`.
  - After the sample with `bit_cnt` == 7, go to `S_PARITY` (if compiled in) or `S_STOP`.
- `S_PARITY`: one bit period, sampled the same way. Records the mismatch result `perr`.
- `S_STOP`: sample once at CLKS_PER_BIT − 1.
  - Sample 1 and no `perr`: load `data_o`, pulse `rx_done_o`, go to `S_IDLE`.
  - Sample 1 and `perr`: pulse `parity_err_o`, leave `data_o` unchanged, go to `S_IDLE`.
  - Sample 0: pulse `frame_err_o`, leave `data_o` unchanged, go to `S_BREAK`. A framing error takes precedence over a parity error, so only `frame_err_o` pulses.
- `S_BREAK`: wait for `rx_s` == 1, then go to `S_IDLE`. A line held low therefore never produces repeated bytes.
- Returning to `S_IDLE` at mid-stop-bit lets a back-to-back start bit be caught with no lost byte.

## Timing
- Reset values:
  - state = `S_IDLE`; `data_o` = 8'h00.
  - `rx_done_o`, `frame_err_o`, `parity_err_o`, `busy_o` = 0.
  - Counters and shift register = 0.
- Synchronizer latency is 2 cycles. `busy_o` rises on the 3rd rising edge after `rx_i` falls.
- Start-bit sample lands CLKS_PER_BIT/2 cycles after `S_START` entry. Each following bit is sampled CLKS_PER_BIT cycles after the previous sample.
- `rx_done_o`, `data_o` update and the error pulses are all registered. They assert in the cycle after the stop sample and last exactly one cycle.
- The downstream stage must accept a strobe without a handshake. There is no backpressure: strobes are at least 10×CLKS_PER_BIT cycles apart.
- Reset asserted mid-frame aborts the frame immediately, with no strobe and no error. After release, the block waits for a new falling edge; the partial frame is not resumed.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds `S_PARITY`, using even parity: the XOR of 8 data bits plus the parity bit must be 0.
  - Frame is 11 bits, and `parity_err_o` is live.
- `UART_RX_PARITY_EN` undefined:
  - No `S_PARITY` state; `S_DATA` goes directly to `S_STOP`.
  - Frame is 10 bits, and `parity_err_o` is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - `state_t` (logic [2:0] enum).
  - `P_DATA_BITS` = 8.
  - `P_PARITY_EVEN` = 1'b0.
- Sub-module `sync_2ff` holds the synchronizer, parameterized reset value, default 1. It is reused by future async inputs.

## Test plan
All scenarios use CLKS_PER_BIT = 8 and drive `rx_i` bit-aligned.
- Byte 8'hA5 with valid stop → exactly one `rx_done_o` pulse, `data_o` = 8'hA5, no error pulses, `busy_o` low 1 cycle later.
- Back-to-back 8'h01, 8'h02, 8'h7F (command write sequence) with no idle gap → three strobes in order with matching `data_o`. The downstream command FSM sees WR, addr 02, data 7F.
- 3-cycle low glitch on idle line → `busy_o` pulses, then returns to idle. No strobe, no error.
- Byte 8'h3C with stop bit 0, line then held low 40 cycles → one `frame_err_o` pulse, `data_o` keeps its prior value, no further activity until the line goes high.
- `rst_n` low during bit 4 of 8'hFF, released, then 8'h55 sent → no strobe for the aborted byte, `data_o` = 8'h55 after the second frame.
- With `UART_RX_PARITY_EN`: 8'h03 with parity bit 1 → `parity_err_o` pulse, no `rx_done_o`. Same byte with parity bit 0 → `rx_done_o`, `data_o` = 8'h03.
